// File: rtl/cmplx_add_pipe.sv
// Two-stage complex-product adder: re = ac - bd (17-bit two's complement), im = ad + bc.
// Byte-sliced carry chain with valid/ready handshaking and a two-deep skid.
module cmplx_add_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ac,
  input  logic [15:0] bd,
  input  logic [15:0] ad,
  input  logic [15:0] bc,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] re,
  output logic [16:0] im,
  output logic        out_valid,
  input  logic        out_ready
);

  logic        v1_reg;
  logic        v2_reg;
  logic [7:0]  re_lo_reg;
  logic [7:0]  im_lo_reg;
  logic        cr_reg;
  logic        ci_reg;
  logic [7:0]  ac_hi_reg;
  logic [7:0]  bd_hi_reg;
  logic [7:0]  ad_hi_reg;
  logic [7:0]  bc_hi_reg;
  logic [16:0] re_reg;
  logic [16:0] im_reg;

  logic        adv2;
  logic        in_xfer;
  logic        out_xfer;
  logic [8:0]  re_lo_next;
  logic [8:0]  im_lo_next;
  logic [8:0]  re_hi_next;
  logic [8:0]  im_hi_next;

  assign adv2     = v1_reg && (!v2_reg || out_ready);
  assign in_ready = !v1_reg || adv2;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = v2_reg && out_ready;

  // Subtraction as a + ~b + 1; bit 8 of each partial sum is the byte carry-out.
  assign re_lo_next = {1'b0, ac[7:0]} + {1'b0, ~bd[7:0]} + 9'd1;
  assign im_lo_next = {1'b0, ad[7:0]} + {1'b0, bc[7:0]};
  assign re_hi_next = {1'b0, ac_hi_reg} + {1'b0, ~bd_hi_reg} + {8'd0, cr_reg};
  assign im_hi_next = {1'b0, ad_hi_reg} + {1'b0, bc_hi_reg} + {8'd0, ci_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      if (in_xfer)
        v1_reg <= 1'b1;
      else if (adv2)
        v1_reg <= 1'b0;
      if (adv2)
        v2_reg <= 1'b1;
      else if (out_xfer)
        v2_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_lo_reg <= 8'd0;
      im_lo_reg <= 8'd0;
      cr_reg    <= 1'b0;
      ci_reg    <= 1'b0;
      ac_hi_reg <= 8'd0;
      bd_hi_reg <= 8'd0;
      ad_hi_reg <= 8'd0;
      bc_hi_reg <= 8'd0;
    end else if (in_xfer) begin
      re_lo_reg <= re_lo_next[7:0];
      cr_reg    <= re_lo_next[8];
      im_lo_reg <= im_lo_next[7:0];
      ci_reg    <= im_lo_next[8];
      ac_hi_reg <= ac[15:8];
      bd_hi_reg <= bd[15:8];
      ad_hi_reg <= ad[15:8];
      bc_hi_reg <= bc[15:8];
    end
  end

  // A missing carry out of the top byte means ac < bd, so the sign bit is its inverse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_reg <= 17'd0;
      im_reg <= 17'd0;
    end else if (adv2) begin
      re_reg <= {~re_hi_next[8], re_hi_next[7:0], re_lo_reg};
      im_reg <= {im_hi_next[8], im_hi_next[7:0], im_lo_reg};
    end
  end

  assign re        = re_reg;
  assign im        = im_reg;
  assign out_valid = v2_reg;

endmodule

// File: tb/tb_cmplx_add_pipe.sv
// Directed and randomized checks for cmplx_add_pipe: arithmetic, latency,
// back-pressure, streaming, mid-flight reset and random handshake traffic.
module tb_cmplx_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ac = '0;
  logic [15:0] bd = '0;
  logic [15:0] ad = '0;
  logic [15:0] bc = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] re;
  logic [16:0] im;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmplx_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .ac        (ac),
    .bd        (bd),
    .ad        (ad),
    .bc        (bc),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .re        (re),
    .im        (im),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: full-width subtraction/addition, no byte slicing.
  function automatic logic [33:0] model(input logic [15:0] a_c, input logic [15:0] b_d,
                                        input logic [15:0] a_d, input logic [15:0] b_c);
    logic [16:0] r;
    logic [16:0] i;
    r = {1'b0, a_c} - {1'b0, b_d};
    i = {1'b0, a_d} + {1'b0, b_c};
    return {r, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d, input logic v);
    ac = a; bd = b; ad = c; bc = d; in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (re !== 17'h0) begin n_fail++; $display("FAIL reset_re: got %h want 00000", re); end
    n_checks++; if (im !== 17'h0) begin n_fail++; $display("FAIL reset_im: got %h want 00000", im); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    drive(16'h1234, 16'h0034, 16'h00FF, 16'h0001, 1'b1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: out_valid got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_lat2: out_valid got %b want 1", out_valid); end
    n_checks++; if (re !== 17'h01200) begin n_fail++; $display("FAIL basic_re: got %h want 01200", re); end
    n_checks++; if (im !== 17'h00100) begin n_fail++; $display("FAIL basic_im: got %h want 00100", im); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid); end
    $display("test_basic done re=%h im=%h", re, im);
  endtask

  task automatic test_boundary();
    out_ready = 1'b1;
    drive(16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    drive(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bound_a_valid: got %b want 1", out_valid); end
    n_checks++; if (re !== 17'h1FFFF) begin n_fail++; $display("FAIL bound_a_re: got %h want 1ffff", re); end
    n_checks++; if (im !== 17'h1FFFE) begin n_fail++; $display("FAIL bound_a_im: got %h want 1fffe", im); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bound_b_valid: got %b want 1", out_valid); end
    n_checks++; if (re !== 17'h0FFFF) begin n_fail++; $display("FAIL bound_b_re: got %h want 0ffff", re); end
    n_checks++; if (im !== 17'h00000) begin n_fail++; $display("FAIL bound_b_im: got %h want 00000", im); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bound_drain: out_valid got %b want 0", out_valid); end
    $display("test_boundary done");
  endtask

  task automatic test_backpressure();
    logic [15:0] s_ac [4];
    logic [15:0] s_bd [4];
    logic [15:0] s_ad [4];
    logic [15:0] s_bc [4];
    logic [33:0] q [$];
    logic [33:0] first;
    int sent;
    int got;
    s_ac = '{16'h8001, 16'h0010, 16'h7F7F, 16'h00FF};
    s_bd = '{16'h0002, 16'h0100, 16'h0080, 16'hFF00};
    s_ad = '{16'h1111, 16'hFF01, 16'h8080, 16'h0000};
    s_bc = '{16'h2222, 16'h00FF, 16'h8080, 16'h0001};
    first = model(s_ac[0], s_bd[0], s_ad[0], s_bc[0]);
    sent = 0;
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      out_ready = !(k >= 2 && k <= 5);
      if (sent < 4) drive(s_ac[sent], s_bd[sent], s_ad[sent], s_bc[sent], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (k == 2) begin
        n_checks++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d sets want 2", sent); end
      end
      if (k >= 2 && k <= 5) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b want 0", k, in_ready); end
        n_checks++; if (out_valid !== 1'b1 || {re, im} !== first) begin
          n_fail++; $display("FAIL bp_stable cyc %0d: got v=%b %h/%h want v=1 %h/%h", k, out_valid, re, im, first[33:17], first[16:0]);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(ac, bd, ad, bc));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL bp_extra: unexpected result %h/%h", re, im); end
        else begin
          if ({re, im} !== q[0]) begin n_fail++; $display("FAIL bp_data #%0d: got %h/%h want %h/%h", got, re, im, q[0][33:17], q[0][16:0]); end
          void'(q.pop_front());
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d results want 4", got); end
    $display("test_backpressure done results=%0d", got);
  endtask

  task automatic test_stream();
    logic [33:0] exp_v [8];
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        drive(16'h0101 * 16'(k + 1), 16'h00F0 + 16'(k * 3), 16'hFE00 + 16'(k), 16'h0300 * 16'(k), 1'b1);
        exp_v[k] = model(ac, bd, ad, bc);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 8) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc %0d: got %b want 1", k, in_ready); end
      end
      n_checks++;
      if (k >= 2 && k < 10) begin
        if (out_valid !== 1'b1 || {re, im} !== exp_v[k-2]) begin
          n_fail++; $display("FAIL stream_out #%0d: got v=%b %h/%h want v=1 %h/%h", k - 2, out_valid, re, im, exp_v[k-2][33:17], exp_v[k-2][16:0]);
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL stream_idle cyc %0d: out_valid got %b want 0", k, out_valid);
      end
      @(posedge clk);
      #1;
    end
    $display("test_stream done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(16'h4000, 16'h0001, 16'h0123, 16'h0456, 1'b1);
    tick();
    drive(16'h0002, 16'h0003, 16'h0789, 16'h0ABC, 1'b1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (re !== 17'h0 || im !== 17'h0) begin n_fail++; $display("FAIL rmid_data: got %h/%h want 00000/00000", re, im); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale cyc %0d: out_valid got %b want 0", k, out_valid); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [33:0] q [$];
    logic [33:0] prev_out;
    logic        prev_stall;
    logic        exp_ready;
    int sent;
    int got;
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            (sent < 10000) && ($urandom_range(0, 9) < 7));
      out_ready = (sent >= 10000) || ($urandom_range(0, 9) < 7);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || {re, im} !== prev_out) begin
          n_fail++; $display("FAIL rand_hold cyc %0d: got v=%b %h/%h want v=1 %h/%h", cyc, out_valid, re, im, prev_out[33:17], prev_out[16:0]);
        end
      end
      exp_ready = (q.size() < 2) || out_ready;
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, exp_ready); end
      n_checks++; if (out_valid === 1'b1 && q.size() == 0) begin n_fail++; $display("FAIL rand_empty cyc %0d: out_valid with empty pipeline", cyc); end
      if (in_valid && in_ready) begin
        q.push_back(model(ac, bd, ad, bc));
        sent++;
      end
      if (out_valid && out_ready && q.size() > 0) begin
        n_checks++;
        if ({re, im} !== q[0]) begin n_fail++; $display("FAIL rand_data #%0d: got %h/%h want %h/%h", got, re, im, q[0][33:17], q[0][16:0]); end
        void'(q.pop_front());
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {re, im};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++; if (got != 10000) begin n_fail++; $display("FAIL rand_count: got %0d results want 10000", got); end
    $display("test_random done sets=%0d results=%0d", sent, got);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmplx_add_pipe.md
CMPLX_ADD_PIPE -- requirements
Module: cmplx_add_pipe

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 ac  input  16  unsigned product a*c from the upstream 8x8 multiplier.
REQ-005 bd  input  16  unsigned product b*d.
REQ-006 ad  input  16  unsigned product a*d.
REQ-007 bc  input  16  unsigned product b*c.
REQ-008 in_valid  input  1  ac/bd/ad/bc hold a valid operand set.
REQ-009 in_ready  output  1  block accepts an operand set this cycle.
REQ-010 re  output  17  real part ac-bd, two's complement.
REQ-011 im  output  17  imaginary part ad+bc, unsigned.
REQ-012 out_valid  output  1  re/im hold a valid result.
REQ-013 out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-014 SHALL transfer input when in_valid&&in_ready at a rising edge, and output when out_valid&&out_ready.
REQ-015 SHALL use a 2-stage pipeline, S1 then S2, with one valid flag per stage (v1, v2).
REQ-016 S1 SHALL register the low-byte results and carries:
  - re_lo = ac[7:0]+~bd[7:0]+1, with carry-out cr;
  - im_lo = ad[7:0]+bc[7:0], with carry-out ci;
  - raw upper bytes ac[15:8], bd[15:8], ad[15:8], bc[15:8].
REQ-017 S2 SHALL register the final results:
  - re[15:8] = ac_hi+~bd_hi+cr, with carry-out c16r, and re[16] = ~c16r;
  - im[15:8] = ad_hi+bc_hi+ci, and im[16] = carry-out of that sum;
  - low bytes passed through from S1.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid, when not stalled.
REQ-019 adv2 = v1 && (!v2 || out_ready); S2 SHALL load S1 contents and set v2 on adv2.
REQ-020 v2 SHALL clear on an output transfer without adv2.
REQ-021 in_ready = !v1 || adv2, combinational; S1 SHALL load on an input transfer.
REQ-022 v1 SHALL clear when adv2 occurs without an input transfer.
REQ-023 Throughput SHALL be one result per cycle while out_ready=1.
REQ-024 Simultaneous input transfer, S1→S2 advance and output transfer in one cycle SHALL all complete with no loss or duplication.
REQ-025 When out_ready=0 and v2=1, re/im/out_valid SHALL hold stable.
REQ-026 When out_ready=0 and v2=1, at most one further operand set SHALL be held in S1, after which in_ready=0.
REQ-027 Data registers SHALL not change when their stage does not load.
REQ-028 in_valid=0 SHALL never create a result; input values while in_ready=0 SHALL be ignored.

Reset
REQ-029 While rst=1, v1, v2, out_valid, re, im and all S1 data SHALL be 0, with in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operand sets; no result of them SHALL appear after release.
REQ-031 The first input transfer SHALL be possible on the first rising edge with rst=0.

Verification
REQ-032 ac=0x1234, bd=0x0034, ad=0x00FF, bc=0x0001, out_ready=1 -> 2 cycles later out_valid=1, re=0x01200, im=0x00100.
REQ-033 ac=0x0000, bd=0x0001, ad=0xFFFF, bc=0xFFFF -> re=0x1FFFF (-1), im=0x1FFFE; ac=0xFFFF, bd=0x0000 -> re=0x0FFFF.
REQ-034 Back-pressure case -> all results emerge in order, unchanged, none lost:
  - stimulus: 4 back-to-back sets, out_ready=0 for cycles 2-5;
  - required: sets 1-2 accepted, in_ready=0 until out_ready returns, outputs stable while stalled.
REQ-035 Continuous stream of 8 sets with out_ready=1 -> 8 consecutive out_valid cycles, 1 result per cycle, values matching a reference model.
REQ-036 Reset pulse one cycle after 2 sets accepted -> out_valid=0, re=im=0, in_ready=1; after release no stale result appears.
REQ-037 Random valid/ready toggling over 10k sets SHALL match a scoreboard, with no out_valid while S2 is empty.
